// File: rtl/alu_core_if.sv
// Operand/result bundle for alu_core: operands and opcode toward the ALU, registered result and flags back.
interface alu_core_if;
    logic        in_valid;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [2:0]  ALUControl;
    logic [31:0] ALUResult;
    logic        zero;
    logic        negative;
    logic        carry;
    logic        overflow;
    logic        out_valid;

    modport master (
        output in_valid, SrcA, SrcB, ALUControl,
        input  ALUResult, zero, negative, carry, overflow, out_valid
    );

    modport slave (
        input  in_valid, SrcA, SrcB, ALUControl,
        output ALUResult, zero, negative, carry, overflow, out_valid
    );
endinterface

// File: rtl/alu_core.sv
// 32-bit ALU with registered result and NZCV flags; one-cycle latency.
// Accepts an operation every cycle; no backpressure, idle cycles hold the last result.
module alu_core (
    input  logic   clk,
    input  logic   reset,
    alu_core_if.slave bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    logic [31:0] a, b, b_op;
    logic [32:0] sum;
    logic        sub_mode;
    logic        add_ov;
    logic [31:0] res_d;
    logic        carry_d;
    logic        ovf_d;

    logic [31:0] result_q;
    logic        zero_q, neg_q, carry_q, ovf_q, vld_q;

    assign a = bus.SrcA;
    assign b = bus.SrcB;

    // SLT shares the subtractor so its sign/overflow come from the same A-B difference.
    always_comb begin
        sub_mode = (bus.ALUControl == OP_SUB) || (bus.ALUControl == OP_SLT);
        b_op     = sub_mode ? ~b : b;
        sum      = {1'b0, a} + {1'b0, b_op} + {32'd0, sub_mode};
        add_ov   = (a[31] == b_op[31]) && (sum[31] != a[31]);
        res_d    = 32'd0;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        case (bus.ALUControl)
            OP_ADD, OP_SUB: begin
                res_d   = sum[31:0];
                carry_d = sum[32];
                ovf_d   = add_ov;
            end
            OP_AND:  res_d = a & b;
            OP_OR:   res_d = a | b;
            OP_XOR:  res_d = a ^ b;
            OP_SLT:  res_d = {31'd0, sum[31] ^ add_ov};
            OP_SLL:  res_d = a << b[4:0];
            OP_SRL:  res_d = a >> b[4:0];
            default: res_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= 32'd0;
            zero_q   <= 1'b1;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            vld_q <= bus.in_valid;
            if (bus.in_valid) begin
                result_q <= res_d;
                zero_q   <= (res_d == 32'd0);
                neg_q    <= res_d[31];
                carry_q  <= carry_d;
                ovf_q    <= ovf_d;
            end
        end
    end

    assign bus.ALUResult = result_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = neg_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core with hand-computed expected results and flags.
module tb_alu_core;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    alu_core_if bus();

    alu_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] r, input logic z, input logic n,
                             input logic c, input logic v, input logic ov);
        check({tag, ".result"},    bus.ALUResult,       r);
        check({tag, ".zero"},      {31'd0, bus.zero},     {31'd0, z});
        check({tag, ".negative"},  {31'd0, bus.negative}, {31'd0, n});
        check({tag, ".carry"},     {31'd0, bus.carry},    {31'd0, c});
        check({tag, ".overflow"},  {31'd0, bus.overflow}, {31'd0, v});
        check({tag, ".out_valid"}, {31'd0, bus.out_valid},{31'd0, ov});
    endtask

    // Drive on the falling edge, check 1 time unit after the capturing rising edge.
    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [2:0] ctl,
                      input logic [31:0] r, input logic z, input logic n, input logic c, input logic v);
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.SrcA       = a;
        bus.SrcB       = b;
        bus.ALUControl = ctl;
        @(posedge clk);
        #1;
        check_all(tag, r, z, n, c, v, 1'b1);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.SrcA       = 32'h0;
        bus.SrcB       = 32'h0;
        bus.ALUControl = 3'b000;

        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back stream: in_valid stays high across consecutive vectors.
        op("and",      32'h11,       32'h11,       3'b010, 32'h11,       1'b0, 1'b0, 1'b0, 1'b0);
        op("or",       32'h11,       32'h11,       3'b011, 32'h11,       1'b0, 1'b0, 1'b0, 1'b0);
        op("add",      32'h11,       32'h11,       3'b000, 32'h22,       1'b0, 1'b0, 1'b0, 1'b0);
        op("sub_eq",   32'h11,       32'h11,       3'b001, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0);
        op("slt_gt",   32'h111,      32'h11,       3'b101, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0);
        op("slt_neg",  32'hFFFFFFFF, 32'h1,        3'b101, 32'h1,        1'b0, 1'b0, 1'b0, 1'b0);
        op("add_ovf",  32'h7FFFFFFF, 32'h1,        3'b000, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
        op("srl",      32'h80000001, 32'h24,       3'b111, 32'h08000000, 1'b0, 1'b0, 1'b0, 1'b0);
        op("add_wrap", 32'hFFFFFFFF, 32'h1,        3'b000, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0);
        op("sub_brw",  32'h0,        32'h1,        3'b001, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        op("sub_ovf",  32'h80000000, 32'h1,        3'b001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
        op("xor",      32'hF0F0F0F0, 32'hFF00FF00, 3'b100, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0, 1'b0);
        op("sll31",    32'h1,        32'hFFFFFFFF, 3'b110, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0);
        op("sll0",     32'h3,        32'h0,        3'b110, 32'h3,        1'b0, 1'b0, 1'b0, 1'b0);
        op("slt_ov1",  32'h80000000, 32'h7FFFFFFF, 3'b101, 32'h1,        1'b0, 1'b0, 1'b0, 1'b0);
        op("slt_ov0",  32'h7FFFFFFF, 32'h80000000, 3'b101, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0);
        op("srl_fill", 32'hFFFFFFFF, 32'h1F,       3'b111, 32'h1,        1'b0, 1'b0, 1'b0, 1'b0);

        // Idle cycles with different operands on the bus: outputs must hold.
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.SrcA       = 32'h7FFFFFFF;
        bus.SrcB       = 32'h1;
        bus.ALUControl = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check_all("hold", 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset between edges while a fresh result is being presented.
        op("pre_rst", 32'h7FFFFFFF, 32'h1, 3'b000, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_all("mid_rst", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("rst_edge", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        op("post_rst", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b000, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b1, 1'b0);

        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_all("idle_end", 32'hFFFFFFFE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
